// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side stream between uart_rx_ctrl and whatever drains its FIFO.
// The controller is the master (presents the FWFT head); the consumer is the
// slave (returns i_data_ready).
//   o_data_valid        FIFO non-empty
//   o_data              head data byte
//   o_data_parity_error head word parity error
//   o_data_frame_error  head word frame error
//   i_data_ready        consumer pops when high together with o_data_valid
interface uart_rx_ctrl_if;
    logic       o_data_valid;
    logic [7:0] o_data;
    logic       o_data_parity_error;
    logic       o_data_frame_error;
    logic       i_data_ready;

    modport master (
        output o_data_valid,
        output o_data,
        output o_data_parity_error,
        output o_data_frame_error,
        input  i_data_ready
    );

    modport slave (
        input  o_data_valid,
        input  o_data,
        input  o_data_parity_error,
        input  o_data_frame_error,
        output i_data_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: glue between a uart_rx receiver and the register/bus side.
//   - Holds the receiver's applied configuration; updates requested while a
//     frame is in flight are shadowed and applied on the frame's done strobe.
//   - Captures completed frames into an FWFT FIFO with per-word error flags.
//   - Drives RTS with high/low-mark hysteresis, sticky overrun and
//     character-timeout flags.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_cfg_*, i_cfg_update      requested config and its load pulse
//   o_cfg_pending              an update is waiting for the frame to end
//   o_rx_*                     applied config towards the receiver
//   i_rx_started/done/...      receiver status and completed word
//   data_if                    FWFT consumer stream (master side)
//   o_fifo_level, o_rts, o_overrun, i_clear_overrun, o_timeout
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH         = 16,
    parameter int RTS_HIGH_MARK      = 12,
    parameter int RTS_LOW_MARK       = 4,
    parameter int TIMEOUT_BITS       = 40,
    parameter int DEFAULT_BIT_LENGTH = 868
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [31:0]                   i_cfg_bit_length,
    input  logic                          i_cfg_msb_first,
    input  logic [1:0]                    i_cfg_stop_bit_mode,
    input  logic                          i_cfg_hw_flow_control_enable,
    input  logic                          i_cfg_parity_enable,
    input  logic                          i_cfg_update,
    output logic                          o_cfg_pending,
    output logic [31:0]                   o_rx_bit_length,
    output logic                          o_rx_msb_first,
    output logic [1:0]                    o_rx_stop_bit_mode,
    output logic                          o_rx_hw_flow_control_enable,
    input  logic                          i_rx_started,
    input  logic                          i_rx_done,
    input  logic                          i_rx_frame_error,
    input  logic                          i_rx_parity_error,
    input  logic [8:0]                    i_rx_word,
    uart_rx_ctrl_if.master                data_if,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_rts,
    output logic                          o_overrun,
    input  logic                          i_clear_overrun,
    output logic                          o_timeout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_HIGH = LVL_W'(RTS_HIGH_MARK);
    localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(RTS_LOW_MARK);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_BITS);

    typedef enum logic {CFG_IDLE = 1'b0, CFG_WAIT = 1'b1} cfg_state_t;

    // The received parity bit itself is not kept; only the checked result is.
    logic unused_parity_bit;
    assign unused_parity_bit = i_rx_word[8];

    // ---------------- frame tracking ----------------
    logic frame_active_q, frame_active_d;
    always_comb begin
        frame_active_d = frame_active_q;
        if (i_rx_done)         frame_active_d = 1'b0;   // done wins
        else if (i_rx_started) frame_active_d = 1'b1;
    end

    // ---------------- config sequencer ----------------
    cfg_state_t state_q, state_d;
    logic apply_now, apply_shadow, snap_shadow;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= CFG_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_IDLE: if (i_cfg_update && (frame_active_q || i_rx_started)) state_d = CFG_WAIT;
            CFG_WAIT: if (i_rx_done) state_d = CFG_IDLE;
            default:  state_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        apply_now    = 1'b0;
        apply_shadow = 1'b0;
        snap_shadow  = 1'b0;
        case (state_q)
            CFG_IDLE: begin
                if (i_cfg_update) begin
                    if (!frame_active_q && !i_rx_started) apply_now   = 1'b1;
                    else                                  snap_shadow = 1'b1;
                end
            end
            CFG_WAIT: begin
                // An update coinciding with the done strobe is the latest
                // request, so it is applied directly instead of the shadow.
                if (i_rx_done) begin
                    if (i_cfg_update) apply_now    = 1'b1;
                    else              apply_shadow = 1'b1;
                end else if (i_cfg_update) begin
                    snap_shadow = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic [31:0] bit_len_q, bit_len_d, sh_bit_len_q, sh_bit_len_d;
    logic        msb_q, msb_d, sh_msb_q, sh_msb_d;
    logic [1:0]  stop_q, stop_d, sh_stop_q, sh_stop_d;
    logic        hw_q, hw_d, sh_hw_q, sh_hw_d;
    logic        par_q, par_d, sh_par_q, sh_par_d;

    always_comb begin
        {bit_len_d, msb_d, stop_d, hw_d, par_d} = {bit_len_q, msb_q, stop_q, hw_q, par_q};
        {sh_bit_len_d, sh_msb_d, sh_stop_d, sh_hw_d, sh_par_d} =
            {sh_bit_len_q, sh_msb_q, sh_stop_q, sh_hw_q, sh_par_q};
        if (apply_now)
            {bit_len_d, msb_d, stop_d, hw_d, par_d} = {i_cfg_bit_length, i_cfg_msb_first,
                i_cfg_stop_bit_mode, i_cfg_hw_flow_control_enable, i_cfg_parity_enable};
        else if (apply_shadow)
            {bit_len_d, msb_d, stop_d, hw_d, par_d} = {sh_bit_len_q, sh_msb_q, sh_stop_q, sh_hw_q, sh_par_q};
        if (snap_shadow)
            {sh_bit_len_d, sh_msb_d, sh_stop_d, sh_hw_d, sh_par_d} = {i_cfg_bit_length, i_cfg_msb_first,
                i_cfg_stop_bit_mode, i_cfg_hw_flow_control_enable, i_cfg_parity_enable};
    end

    // ---------------- FIFO ----------------
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, pop, push_ok;
    logic [9:0]       push_word, head_word;

    assign full      = (level_q == LVL_FULL);
    assign pop       = (level_q != '0) && data_if.i_data_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_ok   = i_rx_done && (!full || pop);
    // Uses the parity enable in force before any update applied on this strobe.
    assign push_word = {i_rx_frame_error, i_rx_parity_error & par_q, i_rx_word[7:0]};
    assign head_word = mem[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_word;
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop && level_q != LVL_FULL) level_d = level_q + 1'b1;
        else if (pop && !push_ok)                   level_d = level_q - 1'b1;
    end

    // ---------------- overrun / RTS ----------------
    logic overrun_q, overrun_d, rts_q, rts_d;
    always_comb begin
        overrun_d = overrun_q;
        if (i_rx_done && full && !pop) overrun_d = 1'b1;
        else if (i_clear_overrun)      overrun_d = 1'b0;

        rts_d = rts_q;
        if (!hw_q)                  rts_d = 1'b1;
        else if (level_q >= LVL_HIGH) rts_d = 1'b0;
        else if (level_q <= LVL_LOW)  rts_d = 1'b1;
    end

    // ---------------- character timeout ----------------
    logic [31:0]     cyc_q, cyc_d, eff_len;
    logic [TO_W-1:0] bits_q, bits_d;
    logic            timeout_q, timeout_d, count_en;

    assign eff_len  = (bit_len_q <= 32'd1) ? 32'd1 : bit_len_q;
    assign count_en = (level_q != '0) && !frame_active_q && !i_rx_done && !pop;

    always_comb begin
        cyc_d     = cyc_q;
        bits_d    = bits_q;
        timeout_d = timeout_q;
        if (i_rx_done || pop || i_rx_started) begin
            cyc_d  = '0;
            bits_d = '0;
        end else if (count_en) begin
            // >= keeps the wrap safe if the bit length shrinks mid-count.
            if (cyc_q >= eff_len - 32'd1) begin
                cyc_d = '0;
                if (bits_q != TO_MAX) bits_d = bits_q + 1'b1;
            end else begin
                cyc_d = cyc_q + 32'd1;
            end
        end
        if (pop || level_d == '0)  timeout_d = 1'b0;
        else if (bits_d == TO_MAX) timeout_d = 1'b1;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_active_q <= 1'b0;
            bit_len_q <= 32'(DEFAULT_BIT_LENGTH);
            {msb_q, stop_q, hw_q, par_q} <= '0;
            {sh_bit_len_q, sh_msb_q, sh_stop_q, sh_hw_q, sh_par_q} <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b1;
            cyc_q     <= '0;
            bits_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            frame_active_q <= frame_active_d;
            {bit_len_q, msb_q, stop_q, hw_q, par_q} <= {bit_len_d, msb_d, stop_d, hw_d, par_d};
            {sh_bit_len_q, sh_msb_q, sh_stop_q, sh_hw_q, sh_par_q} <=
                {sh_bit_len_d, sh_msb_d, sh_stop_d, sh_hw_d, sh_par_d};
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            rts_q     <= rts_d;
            cyc_q     <= cyc_d;
            bits_q    <= bits_d;
            timeout_q <= timeout_d;
        end
    end

    // ---------------- outputs ----------------
    assign o_cfg_pending               = (state_q == CFG_WAIT);
    assign o_rx_bit_length             = bit_len_q;
    assign o_rx_msb_first              = msb_q;
    assign o_rx_stop_bit_mode          = stop_q;
    assign o_rx_hw_flow_control_enable = hw_q;
    assign data_if.o_data_valid        = (level_q != '0);
    assign data_if.o_data              = (level_q != '0) ? head_word[7:0] : 8'h00;
    assign data_if.o_data_parity_error = (level_q != '0) && head_word[8];
    assign data_if.o_data_frame_error  = (level_q != '0) && head_word[9];
    assign o_fifo_level                = level_q;
    assign o_rts                       = rts_q;
    assign o_overrun                   = overrun_q;
    assign o_timeout                   = timeout_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int HIGH  = 12;
    localparam int LOW   = 4;
    localparam int TBITS = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_len = 32'd868;
    logic        cfg_msb = 1'b0, cfg_hw = 1'b0, cfg_par = 1'b0, cfg_upd = 1'b0;
    logic [1:0]  cfg_stop = 2'd0;
    logic        cfg_pending;
    logic [31:0] rx_len;
    logic        rx_msb, rx_hw;
    logic [1:0]  rx_stop;
    logic        started = 1'b0, done = 1'b0, fe = 1'b0, pe = 1'b0;
    logic [8:0]  word = 9'd0;
    logic [4:0]  level;
    logic        rts, overrun, clr_ovr = 1'b0, timeout;

    uart_rx_ctrl_if dif ();

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_cfg_bit_length(cfg_len), .i_cfg_msb_first(cfg_msb),
        .i_cfg_stop_bit_mode(cfg_stop), .i_cfg_hw_flow_control_enable(cfg_hw),
        .i_cfg_parity_enable(cfg_par), .i_cfg_update(cfg_upd),
        .o_cfg_pending(cfg_pending), .o_rx_bit_length(rx_len),
        .o_rx_msb_first(rx_msb), .o_rx_stop_bit_mode(rx_stop),
        .o_rx_hw_flow_control_enable(rx_hw),
        .i_rx_started(started), .i_rx_done(done), .i_rx_frame_error(fe),
        .i_rx_parity_error(pe), .i_rx_word(word),
        .data_if(dif),
        .o_fifo_level(level), .o_rts(rts), .o_overrun(overrun),
        .i_clear_overrun(clr_ovr), .o_timeout(timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue of {frame_err, parity_err, data},
    // timeout as a plain count of idle cycles against TIMEOUT_BITS * bit length.
    logic [9:0]  m_q[$];
    logic [31:0] m_len, sh_len;
    logic        m_msb, m_hw, m_par, sh_msb, sh_hw, sh_par;
    logic [1:0]  m_stop, sh_stop;
    logic        m_wait, m_fa, m_ovr, m_rts, m_to;
    int          m_idle;

    task automatic model_reset();
        m_q.delete();
        m_len = 32'd868; {m_msb, m_hw, m_par, m_stop} = '0;
        {sh_len, sh_msb, sh_hw, sh_par, sh_stop} = '0;
        m_wait = 0; m_fa = 0; m_ovr = 0; m_rts = 1; m_to = 0; m_idle = 0;
    endtask

    task automatic model_step();
        bit pop, full, cnt;
        int eff;
        int sz;
        sz   = m_q.size();
        pop  = (sz > 0) && dif.i_data_ready;
        full = (sz == DEPTH);
        eff  = (m_len <= 1) ? 1 : int'(m_len);
        cnt  = (sz > 0) && !m_fa && !done && !pop;
        // RTS follows the level that was already registered.
        if (!m_hw)          m_rts = 1;
        else if (sz >= HIGH) m_rts = 0;
        else if (sz <= LOW)  m_rts = 1;
        if (done && full && !pop) m_ovr = 1;
        else if (clr_ovr)         m_ovr = 0;
        if (done || pop || started) m_idle = 0;
        else if (cnt)               m_idle++;
        if (pop) void'(m_q.pop_front());
        if (done && (!full || pop)) m_q.push_back({fe, pe & m_par, word[7:0]});
        if (pop || m_q.size() == 0)     m_to = 0;
        else if (m_idle >= TBITS * eff) m_to = 1;
        if (!m_wait) begin
            if (cfg_upd) begin
                if (!m_fa && !started)
                    {m_len, m_msb, m_stop, m_hw, m_par} = {cfg_len, cfg_msb, cfg_stop, cfg_hw, cfg_par};
                else begin
                    {sh_len, sh_msb, sh_stop, sh_hw, sh_par} = {cfg_len, cfg_msb, cfg_stop, cfg_hw, cfg_par};
                    m_wait = 1;
                end
            end
        end else if (done) begin
            if (cfg_upd)
                {m_len, m_msb, m_stop, m_hw, m_par} = {cfg_len, cfg_msb, cfg_stop, cfg_hw, cfg_par};
            else
                {m_len, m_msb, m_stop, m_hw, m_par} = {sh_len, sh_msb, sh_stop, sh_hw, sh_par};
            m_wait = 0;
        end else if (cfg_upd) begin
            {sh_len, sh_msb, sh_stop, sh_hw, sh_par} = {cfg_len, cfg_msb, cfg_stop, cfg_hw, cfg_par};
        end
        if (done)         m_fa = 0;
        else if (started) m_fa = 1;
    endtask

    task automatic tick();
        logic [9:0] h;
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
        h = (m_q.size() > 0) ? m_q[0] : 10'd0;
        chk("valid",   dif.o_data_valid, m_q.size() > 0);
        chk("data",    dif.o_data, h[7:0]);
        chk("perr",    dif.o_data_parity_error, h[8]);
        chk("ferr",    dif.o_data_frame_error, h[9]);
        chk("level",   level, m_q.size());
        chk("rts",     rts, m_rts);
        chk("overrun", overrun, m_ovr);
        chk("timeout", timeout, m_to);
        chk("pending", cfg_pending, m_wait);
        chk("bitlen",  rx_len, m_len);
        chk("msb",     rx_msb, m_msb);
        chk("stop",    rx_stop, m_stop);
        chk("hw",      rx_hw, m_hw);
    endtask

    task automatic frame(input logic [7:0] d, input logic f, input logic p);
        started = 1; tick(); tick();
        started = 0; done = 1; fe = f; pe = p; word = {1'($urandom), d};
        tick();
        done = 0; fe = 0; pe = 0;
    endtask

    task automatic set_cfg(input logic [31:0] len, input logic hw, input logic par);
        cfg_len = len; cfg_hw = hw; cfg_par = par; cfg_upd = 1;
        tick();
        cfg_upd = 0;
    endtask

    task automatic drain();
        dif.i_data_ready = 1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        dif.i_data_ready = 0;
    endtask

    initial begin
        int n;
        model_reset();
        dif.i_data_ready = 0;
        rst = 1; tick(); tick();
        chk("rst_rts", rts, 1);
        chk("rst_len", rx_len, 868);
        rst = 0; tick();

        // three clean frames, consumer always ready
        dif.i_data_ready = 1;
        frame(8'h55, 0, 0); chk("f1_data", dif.o_data, 8'h55);
        frame(8'hA3, 0, 0); chk("f2_data", dif.o_data, 8'hA3);
        frame(8'h0F, 0, 0); chk("f3_data", dif.o_data, 8'h0F);
        tick(); chk("f_level0", level, 0);
        dif.i_data_ready = 0;

        // config update requested mid-frame waits for done
        started = 1; tick();
        cfg_len = 32'd434; cfg_upd = 1; tick(); cfg_upd = 0;
        chk("cfgw_pend", cfg_pending, 1);
        chk("cfgw_len", rx_len, 868);
        tick(); started = 0; done = 1; word = 9'h011; tick(); done = 0;
        chk("cfgw_len2", rx_len, 434);
        chk("cfgw_pend2", cfg_pending, 0);
        drain();

        // RTS hysteresis
        set_cfg(32'd434, 1, 0);
        for (int i = 0; i < 12; i++) frame(8'($urandom), 0, 0);
        chk("rts_lag", rts, 1);
        tick(); chk("rts_drop", rts, 0);
        dif.i_data_ready = 1;
        for (int i = 0; i < 8; i++) tick();
        dif.i_data_ready = 0;
        chk("rts_lvl4", level, 4);
        tick(); chk("rts_back", rts, 1);

        // fill to full, then overrun
        for (int i = 0; i < 12; i++) frame(8'($urandom), 1'($urandom), 0);
        chk("full_lvl", level, 16);
        frame(8'hEE, 0, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_lvl", level, 16);
        clr_ovr = 1; done = 1; word = 9'h0EF; tick(); done = 0;
        chk("ovr_prio", overrun, 1);
        tick(); clr_ovr = 0;
        chk("ovr_clr", overrun, 0);

        // push and pop together while full
        done = 1; word = 9'h0C3; dif.i_data_ready = 1; tick();
        done = 0; dif.i_data_ready = 0;
        chk("pp_lvl", level, 16);
        chk("pp_ovr", overrun, 0);
        drain();

        // timeout with bit length 10, parity masked by parity_enable=0
        set_cfg(32'd10, 0, 0);
        frame(8'h5A, 0, 1);
        chk("pmask", dif.o_data_parity_error, 0);
        n = 0;
        while (!timeout && n < 1000) begin tick(); n++; end
        chk("to_cycles", n, 400);
        dif.i_data_ready = 1; tick(); dif.i_data_ready = 0;
        chk("to_clr", timeout, 0);

        // randomized traffic against the model
        set_cfg(32'd10, 1, 1);
        for (int blk = 0; blk < 30; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 90);
            for (int c = 0; c < 100; c++) begin
                started = ($urandom_range(0, 7) == 0);
                done    = ($urandom_range(0, 5) == 0);
                fe      = 1'($urandom);
                pe      = 1'($urandom);
                word    = 9'($urandom);
                clr_ovr = ($urandom_range(0, 19) == 0);
                dif.i_data_ready = ($urandom_range(0, 99) < rdy_pct);
                cfg_upd = ($urandom_range(0, 49) == 0);
                cfg_msb = 1'($urandom); cfg_stop = 2'($urandom);
                cfg_hw  = 1'($urandom); cfg_par = 1'($urandom);
                tick();
            end
        end
        {started, done, clr_ovr, cfg_upd} = '0;
        dif.i_data_ready = 0;

        // reset in the middle of a frame
        started = 1; tick(); rst = 1; tick(); started = 0; rst = 0; tick();
        chk("mrst_lvl", level, 0);
        chk("mrst_len", rx_len, 868);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller that sits between the uart_rx receiver and the register/bus side.
- Owns the receiver's configuration and applies updates only at frame boundaries.
- Captures completed frames into a first-word-fall-through (FWFT) FIFO with per-word error flags.
- Drives RTS hardware flow control with hysteresis, and flags overrun and character-timeout conditions.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of two, >= 4
RTS_HIGH_MARK, 12, level at or above which RTS drops
RTS_LOW_MARK, 4, level at or below which RTS re-asserts; must be < RTS_HIGH_MARK
TIMEOUT_BITS, 40, idle bit periods before character timeout
DEFAULT_BIT_LENGTH, 868, bit length (clock cycles) after reset

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_cfg_bit_length  in  32  requested bit length, cycles
i_cfg_msb_first  in  1  requested bit order
i_cfg_stop_bit_mode  in  2  requested stop-bit mode
i_cfg_hw_flow_control_enable  in  1  requested RTS enable
i_cfg_parity_enable  in  1  requested parity-error checking
i_cfg_update  in  1  one-cycle pulse: request config load
o_cfg_pending  out  1  update requested, not yet applied
o_rx_bit_length  out  32  applied config to receiver
o_rx_msb_first  out  1  applied config to receiver
o_rx_stop_bit_mode  out  2  applied config to receiver
o_rx_hw_flow_control_enable  out  1  applied config to receiver
i_rx_started  in  1  receiver in start-bit phase (multi-cycle level)
i_rx_done  in  1  one-cycle frame-complete strobe
i_rx_frame_error  in  1  qualified by i_rx_done
i_rx_parity_error  in  1  qualified by i_rx_done
i_rx_word  in  9  [7:0] data, [8] parity
o_data_valid  out  1  FIFO non-empty
o_data  out  8  head data
o_data_parity_error  out  1  head parity error
o_data_frame_error  out  1  head frame error
i_data_ready  in  1  consumer pop when high with o_data_valid
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored
o_rts  out  1  1 = remote may send
o_overrun  out  1  sticky: a frame was dropped
i_clear_overrun  in  1  clears o_overrun
o_timeout  out  1  sticky character timeout

Behaviour:
- Reset values (i_rst=1, sampled at posedge):
  - o_rx_bit_length=DEFAULT_BIT_LENGTH; msb_first=0; stop_bit_mode=0; hw_flow=0.
  - o_cfg_pending=0; FIFO empty (o_data_valid=0, level=0); o_data/error flags 0.
  - o_rts=1; o_overrun=0; o_timeout=0; all counters 0.
  - Reset mid-frame drops the frame in progress.
- Frame tracking:
  - frame_active sets on i_rx_started.
  - frame_active clears on i_rx_done; done wins over started in the same cycle.
- Config sequencer, states CFG_IDLE and CFG_WAIT:
  - CFG_IDLE, i_cfg_update with !frame_active and !i_rx_started: latch all i_cfg_* into the applied registers next edge. Outputs change 1 cycle after the pulse. Stay in CFG_IDLE.
  - CFG_IDLE, update with a frame active: snapshot i_cfg_* into a shadow; o_cfg_pending=1; go to CFG_WAIT.
  - CFG_WAIT: on i_rx_done, copy shadow to applied next edge; pending=0; return to CFG_IDLE.
  - A second update in CFG_WAIT overwrites the shadow (last wins).
  - A word captured on that i_rx_done uses the old parity_enable.
- Capture (push):
  - On i_rx_done, push {frame_err, parity_err & parity_enable, word[7:0]}.
  - Parity bit word[8] is not stored.
  - Latency: push to empty FIFO gives o_data_valid=1 at the next edge.
- Pop: o_data_valid & i_data_ready, at the edge.
  - Push and pop in the same cycle: both occur; level is unchanged, including when full.
- Overrun:
  - Push when full without a same-cycle pop discards the word and sets o_overrun.
  - Set has priority over i_clear_overrun in the same cycle.
- RTS:
  - If applied hw_flow=0, o_rts=1.
  - Else o_rts goes 0 when the registered level becomes >= RTS_HIGH_MARK.
  - o_rts returns to 1 when the level becomes <= RTS_LOW_MARK.
  - o_rts holds between the marks; it is registered, 1 cycle after the level change.
- Timeout:
  - Counting runs while level>0, !frame_active, no push and no pop.
  - Cycle counter counts to o_rx_bit_length, then increments the bit counter and wraps.
  - Bit counter reaching TIMEOUT_BITS sets o_timeout.
  - Any push, pop, or frame start clears both counters.
  - Pop clears o_timeout; so does the FIFO becoming empty.
  - bit_length of 0 or 1 is treated as 1.
- Pointers: wrap modulo FIFO_DEPTH; level is a separate counter saturating at 0 and FIFO_DEPTH.

Test Plan:
- Reset, push three frames 0x55/0xA3/0x0F with no errors, i_data_ready=1 -> data appears in order, each 1 cycle after its done; level returns to 0.
- i_cfg_update (bit_length=434) while i_rx_started=1 -> o_cfg_pending=1; o_rx_bit_length stays 868 until the cycle after i_rx_done, then 434; pending=0.
- hw_flow=1, ready=0, push 12 frames -> o_rts=0 after the 12th; pop 8 -> o_rts=1 only after level reaches 4.
- Fill to 16, push 17th with ready=0 -> dropped, o_overrun=1, level=16; i_clear_overrun plus simultaneous push-while-full -> o_overrun stays 1.
- Full FIFO, push and pop in the same cycle -> level stays 16, no overrun, new word at tail.
- bit_length=10, one word held, idle -> o_timeout=1 after 400 cycles; pop -> o_timeout=0; parity_error strobe with parity_enable=0 -> o_data_parity_error=0.
